// File: rtl/pong_video_renderer.sv
// pong_video_renderer: VGA raster generator that draws the pong pads, ball and net from a per-frame snapshot of game state.
module pong_video_renderer #(
  parameter int CLK_DIV      = 2,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int PAD_WIDTH    = 8,
  parameter int PAD_HEIGHT   = 64,
  parameter int PAD_DISTANCE = 16,
  parameter int BALL_SIZE    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pad_left,
  input  logic [9:0] pad_right,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic signed [11:0] GY0  = 12'(V_ACTIVE - 1);
  localparam logic signed [11:0] BS1  = 12'(BALL_SIZE - 1);
  localparam logic signed [11:0] PH2  = 12'(PAD_HEIGHT / 2);
  localparam logic signed [11:0] LP0  = 12'(PAD_DISTANCE);
  localparam logic signed [11:0] LP1  = 12'(PAD_DISTANCE + PAD_WIDTH);
  localparam logic signed [11:0] RP0  = 12'(H_ACTIVE - PAD_DISTANCE - PAD_WIDTH);
  localparam logic signed [11:0] RP1  = 12'(H_ACTIVE - PAD_DISTANCE);
  logic [DW-1:0] div;
  logic          pe;
  logic [9:0]    h, v;
  logic [9:0]    sh_pl, sh_pr, sh_bx;
  logic [8:0]    sh_by;
  logic          h_end, v_end, active, hit_ball, hit_pad, hit_net, hs_n, vs_n;
  logic [2:0]    pix;
  logic signed [11:0] x, gy, bx0, bx1, by0, by1, dl, dr;
  assign pe = (div == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div <= '0;
    else div <= (div == DW'(CLK_DIV - 1)) ? '0 : div + 1'b1;
  assign h_end = (h == 10'(H_TOTAL - 1));
  assign v_end = (v == 10'(V_TOTAL - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (pe) begin
      h <= h_end ? '0 : h + 1'b1;
      if (h_end) v <= v_end ? '0 : v + 1'b1;
    end
  // Game state is latched during vertical blanking so a frame never tears.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_pl <= '0;
      sh_pr <= '0;
      sh_bx <= '0;
      sh_by <= '0;
    end else if (pe && h == '0 && v == 10'(V_ACTIVE)) begin
      sh_pl <= pad_left;
      sh_pr <= pad_right;
      sh_bx <= ball_x;
      sh_by <= ball_y;
    end
  always_comb begin
    active   = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
    x        = $signed({2'b00, h});
    gy       = GY0 - $signed({2'b00, v});
    bx0      = $signed({2'b00, sh_bx});
    bx1      = bx0 + BS1;
    by0      = $signed({3'b000, sh_by});
    by1      = by0 + BS1;
    dl       = gy - $signed({2'b00, sh_pl});
    dr       = gy - $signed({2'b00, sh_pr});
    hit_ball = active && x >= bx0 && x <= bx1 && gy >= by0 && gy <= by1;
    hit_pad  = active && ((x >= LP0 && x < LP1 && dl >= -PH2 && dl <= PH2) ||
                          (x >= RP0 && x < RP1 && dr >= -PH2 && dr <= PH2));
    hit_net  = active && (h == 10'(H_ACTIVE / 2 - 1) || h == 10'(H_ACTIVE / 2)) && !v[4];
    pix      = hit_ball ? 3'b110 : hit_pad ? 3'b111 : hit_net ? 3'b010 : 3'b000;
    hs_n     = !(h >= 10'(H_ACTIVE + H_FP) && h < 10'(H_ACTIVE + H_FP + H_SYNC));
    vs_n     = !(v >= 10'(V_ACTIVE + V_FP) && v < 10'(V_ACTIVE + V_FP + V_SYNC));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= 3'b000;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pe && h == '0 && v == '0;
      if (pe) begin
        hsync <= hs_n;
        vsync <= vs_n;
        rgb   <= pix;
      end
    end
endmodule

// File: tb/tb_pong_video_renderer.sv
// tb_pong_video_renderer: checks every clock of a reduced-size raster against a pixel-level model of the game screen.
module tb_pong_video_renderer;
  localparam int CD = 2, HA = 48, HF = 4, HS = 8, HB = 4, VA = 40, VF = 2, VS = 2, VB = 4;
  localparam int PW = 4, PH = 16, PD = 4, BS = 4;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FP = HT * VT;
  logic       clk = 1'b0, rst_n = 1'b1;
  logic [9:0] pad_left = '0, pad_right = '0, ball_x = '0;
  logic [8:0] ball_y = '0;
  logic       hsync, vsync, frame_start;
  logic [2:0] rgb;
  int n, compared, mismatched;
  int sbx, sby, spl, spr;

  pong_video_renderer #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PAD_WIDTH(PW), .PAD_HEIGHT(PH), .PAD_DISTANCE(PD), .BALL_SIZE(BS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pad_left(pad_left), .pad_right(pad_right),
    .ball_x(ball_x), .ball_y(ball_y), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Screen picture in game coordinates: what a player should see at column x, scan row y.
  function automatic logic [2:0] screen(int x, int y);
    int gy, dl, dr;
    bit pad;
    if (x >= HA || y >= VA) return 3'b000;
    gy = VA - 1 - y;
    dl = gy - spl;
    dr = gy - spr;
    if (dl < 0) dl = -dl;
    if (dr < 0) dr = -dr;
    pad = (x >= PD && x < PD + PW && dl <= PH / 2) || (x >= HA - PD - PW && x < HA - PD && dr <= PH / 2);
    if (x >= sbx && x < sbx + BS && gy >= sby && gy < sby + BS) return 3'b110;
    if (pad) return 3'b111;
    if ((x == HA / 2 - 1 || x == HA / 2) && (y / 16) % 2 == 0) return 3'b010;
    return 3'b000;
  endfunction

  task automatic step();
    int p, x, y;
    logic [5:0] exp_v, obs_v;
    @(negedge clk);
    p = n / CD;
    x = p % HT;
    y = (p / HT) % VT;
    exp_v = {!(x >= HA + HF && x < HA + HF + HS), !(y >= VA + VF && y < VA + VF + VS),
             screen(x, y), (n % CD == 0) && (p % FP == 0)};
    obs_v = {hsync, vsync, rgb, frame_start};
    compared++;
    assert (obs_v === exp_v) else begin
      mismatched++;
      $error("FAIL raster clk=%0d x=%0d y=%0d {hs,vs,rgb,fs} got=%b want=%b", n, x, y, obs_v, exp_v);
    end
    if (x == 0 && y == VA && n % CD == 0) begin
      sbx = ball_x; sby = ball_y; spl = pad_left; spr = pad_right;
    end
    n++;
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic check_reset(string tag);
    compared++;
    assert ({hsync, vsync, rgb, frame_start} === 6'b110000) else begin
      mismatched++;
      $error("FAIL %s got=%b want=110000", tag, {hsync, vsync, rgb, frame_start});
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    sbx = 0; sby = 0; spl = 0; spr = 0;
  endtask

  task automatic randomize_inputs();
    ball_x    = 10'($urandom_range(0, 55));
    ball_y    = 9'($urandom_range(0, 45));
    pad_left  = ($urandom_range(0, 7) == 0) ? 10'd1000 : 10'($urandom_range(0, 45));
    pad_right = 10'($urandom_range(0, 45));
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    #1 rst_n = 1'b0;
    #1 check_reset("reset_async_initial");
    repeat (3) @(negedge clk);
    ball_x = 10'd10; ball_y = 9'd20; pad_left = 10'd2; pad_right = 10'd30;
    release_reset();
    run(FP * CD);
    run(FP * CD);
    run(20 * HT * CD);
    ball_x = 10'd30;
    run((FP - 20 * HT) * CD);
    run(FP * CD);
    run(13 * HT * CD + 7);
    #3 rst_n = 1'b0;
    #1 check_reset("reset_async_midframe");
    repeat (3) @(posedge clk);
    #1 check_reset("reset_held");
    ball_x = 10'd5; ball_y = 9'd20; pad_left = 10'd20; pad_right = 10'd999;
    release_reset();
    run(2 * FP * CD);
    for (int f = 0; f < 4; f++) begin
      randomize_inputs();
      for (int i = 0; i < FP * CD; i++) begin
        if ($urandom_range(0, 1499) == 0) randomize_inputs();
        step();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
